sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Downstream consumer of the edge-triggered D flip-flop stage.
- Takes a raw or asynchronous single-bit level and passes it through a reset-clearable synchroniser chain.
- Debounces the synchronised level with a stability counter and FSM.
- Emits a clean level, one-cycle rise/fall strobes and a wrapping edge counter for the stages that follow.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal 2..4).
- STABLE_CYCLES, 4, consecutive equal synchronised samples required to accept a new level (legal 2..255).
- CNT_W, 8, width of EdgeCount.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- D  input  1  raw level (may be asynchronous to Clk).
- Q  output  1  debounced, registered level.
- Rise  output  1  one-cycle strobe; Q has just gone 0->1.
- Fall  output  1  one-cycle strobe; Q has just gone 1->0.
- EdgeCount  output  CNT_W  total accepted edges (rise + fall), wraps.

Behaviour:
- Interface: one clock, Clk; reset is asynchronous and active-high, port Reset.
- Reset: all synchroniser flops 0, FSM in STABLE_LOW, counter 0, Q=0, Rise=0, Fall=0, EdgeCount=0. Reset asserted mid-check abandons the check immediately; no strobe is issued.
- Synchroniser: D shifts through SYNC_STAGES flops; s = last stage.
- FSM states: STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW.
- STABLE_LOW:
  - s=1 -> CHK_HIGH, cnt=1.
  - else stay.
- CHK_HIGH:
  - s=0 -> STABLE_LOW, cnt=0 (glitch rejected; no strobe).
  - s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, Q<=1, Rise<=1, EdgeCount<=EdgeCount+1.
  - else cnt++.
- STABLE_HIGH / CHK_LOW: mirror image of the above; produces Fall and Q<=0.
- Strobes: registered; Rise/Fall high exactly one cycle, coincident with the first cycle of the new Q. Rise and Fall are never high together.
- Latency: D stable before edge E1 -> Q changes after edge E(SYNC_STAGES+STABLE_CYCLES); with defaults, edge E6.
- Minimum pulse: D pulse shorter than STABLE_CYCLES samples at s is never seen on Q.
- EdgeCount: modulo 2^CNT_W; all-ones + 1 -> 0, no flag.
- cnt width: $clog2(STABLE_CYCLES)+1; cnt never exceeds STABLE_CYCLES-1.

Optional Feature:
- Macro SYNC_DEBOUNCE_GLITCH_COUNT_EN.
- Defined:
  - Adds output GlitchCount[7:0], reset 0.
  - Increments on every CHK_HIGH->STABLE_LOW or CHK_LOW->STABLE_HIGH abort.
  - Saturates at 255.
- Undefined: port absent and no logic; all other behaviour identical.

Decomposition:
- Package sync_debounce_pkg:
  - state_t enum {STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW}.
  - Localparam GLITCH_W=8.
  - Function for cnt width.
- One sub-module, sync_chain: parameterised SYNC_STAGES flop chain with async active-high reset, ports Clk, Reset, D, s.
- FSM, counter and strobes stay in sync_debounce.

Test Plan:
- Reset then D=0 for 20 cycles -> Q=0, Rise=Fall=0, EdgeCount=0 throughout.
- D 0->1 before edge 1, held -> Q=1 and Rise=1 after edge 6 only, Rise=0 at edge 7, EdgeCount=1. D 1->0 held -> Fall after 6 edges, EdgeCount=2.
- D high for 3 cycles then low (defaults) -> Q stays 0, no strobes, EdgeCount unchanged; with macro, GlitchCount=1.
- Reset asserted mid-way through CHK_HIGH (cnt=2), asynchronously between edges -> outputs 0 before the next edge. Release with D=1 -> full 6-edge latency restarts.
- CNT_W=2, four full toggles -> EdgeCount 1,2,3,0 (wrap).
- STABLE_CYCLES=2, SYNC_STAGES=3 -> Q follows D 5 edges later; a 1-sample pulse at s is rejected.

Source files
------------

// File: rtl/sync_debounce_pkg.sv
// Shared types and helpers for the sync_debounce slice.
// Optional build macro SYNC_DEBOUNCE_GLITCH_COUNT_EN adds a glitch counter output.
package sync_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    localparam int GLITCH_W = 8;

    // Stability counter width; one spare bit keeps the terminal value comfortably representable.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles) + 1;
    endfunction

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// Reset-clearable flop chain that brings a raw level into the Clk domain.
// Optional build macro SYNC_DEBOUNCE_GLITCH_COUNT_EN has no effect here.
module sync_chain
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic D,
    output logic s
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw level through the chain; the last stage is the usable sample.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], D};
        end
    end

    assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronise, debounce and edge-detect a single-bit level.
// Optional build macro SYNC_DEBOUNCE_GLITCH_COUNT_EN adds GlitchCount (saturating abort counter).
//
// state       | meaning
// ------------+--------------------------------------------------------
// STABLE_LOW  | Q=0 accepted, waiting for s=1
// CHK_HIGH    | s went high, counting consecutive high samples
// STABLE_HIGH | Q=1 accepted, waiting for s=0
// CHK_LOW     | s went low, counting consecutive low samples
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             D,
    output logic             Q,
    output logic             Rise,
    output logic             Fall,
    output logic [CNT_W-1:0] EdgeCount
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    ,
    output logic [GLITCH_W-1:0] GlitchCount
`endif
);

    localparam int               CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    state_t        state;
    logic [CW-1:0] cnt;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .Clk  (Clk),
        .Reset(Reset),
        .D    (s_in_d(D)),
        .s    (s)
    );

    function automatic logic s_in_d(input logic d);
        return d;
    endfunction

    // Debounce FSM with registered level, strobes, edge counter and optional glitch counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            Q         <= 1'b0;
            Rise      <= 1'b0;
            Fall      <= 1'b0;
            EdgeCount <= '0;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
            GlitchCount <= '0;
`endif
        end else begin
            Rise <= 1'b0;
            Fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state <= CHK_HIGH;
                        cnt   <= CW'(1);
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
                        if (GlitchCount != '1) GlitchCount <= GlitchCount + GLITCH_W'(1);
`endif
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_HIGH;
                        cnt       <= '0;
                        Q         <= 1'b1;
                        Rise      <= 1'b1;
                        EdgeCount <= EdgeCount + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= CHK_LOW;
                        cnt   <= CW'(1);
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
                        if (GlitchCount != '1) GlitchCount <= GlitchCount + GLITCH_W'(1);
`endif
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_LOW;
                        cnt       <= '0;
                        Q         <= 1'b0;
                        Fall      <= 1'b1;
                        EdgeCount <= EdgeCount + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default, narrow-counter and fast-debounce instances.
// Optional build macro SYNC_DEBOUNCE_GLITCH_COUNT_EN enables GlitchCount checks.
module tb_sync_debounce;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0;

    logic       q0, r0, f0;
    logic [7:0] ec0;
    logic       q1, r1, f1;
    logic [1:0] ec1;
    logic       q2, r2, f2;
    logic [7:0] ec2;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    logic [7:0] gc0, gc1, gc2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    sync_debounce u0 (
        .Clk(Clk), .Reset(Reset), .D(d0), .Q(q0), .Rise(r0), .Fall(f0), .EdgeCount(ec0)
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        , .GlitchCount(gc0)
`endif
    );

    sync_debounce #(.CNT_W(2)) u1 (
        .Clk(Clk), .Reset(Reset), .D(d1), .Q(q1), .Rise(r1), .Fall(f1), .EdgeCount(ec1)
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        , .GlitchCount(gc1)
`endif
    );

    sync_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) u2 (
        .Clk(Clk), .Reset(Reset), .D(d2), .Q(q2), .Rise(r2), .Fall(f2), .EdgeCount(ec2)
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        , .GlitchCount(gc2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [1:0] wrap_exp [4];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0;

        #12 Reset = 1'b0;

        // idle low, 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_q", q0, 0);
            check("idle_strobes", {r0, f0}, 0);
            check("idle_ec", ec0, 0);
        end

        // rise: Q and Rise at edge 6
        d0 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rise_q_e%0d", e), q0, (e >= 6) ? 1 : 0);
            check($sformatf("rise_r_e%0d", e), r0, (e == 6) ? 1 : 0);
            check($sformatf("rise_f_e%0d", e), f0, 0);
            check($sformatf("rise_ec_e%0d", e), ec0, (e >= 6) ? 1 : 0);
        end

        // fall: Q and Fall at edge 6
        d0 = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("fall_q_e%0d", e), q0, (e >= 6) ? 0 : 1);
            check($sformatf("fall_f_e%0d", e), f0, (e == 6) ? 1 : 0);
            check($sformatf("fall_r_e%0d", e), r0, 0);
            check($sformatf("fall_ec_e%0d", e), ec0, (e >= 6) ? 2 : 1);
        end

        // 3-cycle glitch is rejected
        d0 = 1'b1;
        repeat (3) tick();
        d0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_q", q0, 0);
            check("glitch_strobes", {r0, f0}, 0);
            check("glitch_ec", ec0, 2);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        check("glitch_count", gc0, 1);
`endif

        // async reset in the middle of CHK_HIGH (cnt=2 after 4 edges)
        d0 = 1'b1;
        repeat (4) tick();
        check("pre_reset_q", q0, 0);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_ec", ec0, 0);
        check("async_reset_q", q0, 0);
        check("async_reset_strobes", {r0, f0}, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        check("async_reset_gc", gc0, 0);
`endif
        #1 Reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rst_rise_q_e%0d", e), q0, (e >= 6) ? 1 : 0);
            check($sformatf("rst_rise_r_e%0d", e), r0, (e == 6) ? 1 : 0);
        end
        check("rst_rise_ec", ec0, 1);

        // CNT_W=2 wrap over four accepted edges
        for (int k = 0; k < 4; k++) begin
            d1 = ~d1;
            repeat (8) tick();
            check($sformatf("wrap_ec_%0d", k), ec1, wrap_exp[k]);
            check($sformatf("wrap_q_%0d", k), q1, (k % 2 == 0) ? 1 : 0);
        end

        // SYNC_STAGES=3, STABLE_CYCLES=2: latency 5 edges
        d2 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("fast_q_e%0d", e), q2, (e >= 5) ? 1 : 0);
            check($sformatf("fast_r_e%0d", e), r2, (e == 5) ? 1 : 0);
        end

        // one-sample low pulse is rejected
        d2 = 1'b0;
        tick();
        d2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fast_pulse_q", q2, 1);
            check("fast_pulse_f", f2, 0);
        end
        check("fast_pulse_ec", ec2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
